// File: rtl/writeback_arbiter_pkg.sv
// Shared pipeline constants for the writeback stage: FSM state codes, source ids, register address width.
package writeback_arbiter_pkg;

  localparam int REG_AW = 5;

  typedef logic [0:0] wb_state_t;
  localparam wb_state_t ST_NORMAL = 1'b0;
  localparam wb_state_t ST_STARVE = 1'b1;

  typedef logic src_t;
  localparam src_t SRC_ALU = 1'b0;
  localparam src_t SRC_LD  = 1'b1;

endpackage

// File: rtl/writeback_arbiter_hold_slot.sv
// wb_hold_slot: one-entry result holding register; 1-cycle fill latency.
// Refills in the same cycle it is granted; refuses input during flush and reset.
module wb_hold_slot
  import writeback_arbiter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_data,
  input  logic              grant,
  output logic              hold_valid,
  output logic [REG_AW-1:0] hold_rd,
  output logic [XLEN-1:0]   hold_data
);

  assign in_ready = reset & ~flush & (~hold_valid | grant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold_valid <= 1'b1;
      hold_rd    <= in_rd;
      hold_data  <= in_data;
    end else if (grant) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU and load results into one register-file write port; 2-cycle accept-to-write latency.
// Load wins ties until the ALU has lost STARVE_LIMIT times in a row; per-source ready deasserts while its slot waits.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              write_back_done,
  output logic              done_src
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW:0] LIMIT_W = (CW + 1)'(STARVE_LIMIT);

  logic              alu_hold_valid, ld_hold_valid;
  logic [REG_AW-1:0] alu_hold_rd, ld_hold_rd;
  logic [XLEN-1:0]   alu_hold_data, ld_hold_data;
  logic              grant_alu, grant_ld, grant_any;
  logic [REG_AW-1:0] win_rd;
  logic [XLEN-1:0]   win_data;
  wb_state_t         state;
  logic [CW-1:0]     loss_cnt;
  logic [CW:0]       loss_inc;

  wb_hold_slot #(.XLEN(XLEN)) u_alu_slot (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (alu_valid),
    .in_ready   (alu_ready),
    .in_rd      (alu_rd),
    .in_data    (alu_data),
    .grant      (grant_alu),
    .hold_valid (alu_hold_valid),
    .hold_rd    (alu_hold_rd),
    .hold_data  (alu_hold_data)
  );

  wb_hold_slot #(.XLEN(XLEN)) u_ld_slot (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (ld_valid),
    .in_ready   (ld_ready),
    .in_rd      (ld_rd),
    .in_data    (ld_data),
    .grant      (grant_ld),
    .hold_valid (ld_hold_valid),
    .hold_rd    (ld_hold_rd),
    .hold_data  (ld_hold_data)
  );

  // A flushed cycle retires nothing; the slots are being emptied anyway.
  assign grant_ld  = ~flush & ld_hold_valid & (~alu_hold_valid | (state == ST_NORMAL));
  assign grant_alu = ~flush & alu_hold_valid & ~grant_ld;
  assign grant_any = grant_alu | grant_ld;
  assign win_rd    = grant_ld ? ld_hold_rd : alu_hold_rd;
  assign win_data  = grant_ld ? ld_hold_data : alu_hold_data;
  assign loss_inc  = {1'b0, loss_cnt} + {{CW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_NORMAL;
      loss_cnt        <= '0;
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      write_back_done <= 1'b0;
      done_src        <= SRC_ALU;
    end else if (flush) begin
      state           <= ST_NORMAL;
      loss_cnt        <= '0;
      rf_we           <= 1'b0;
      write_back_done <= 1'b0;
    end else begin
      write_back_done <= grant_any;
      rf_we           <= grant_any && (win_rd != '0);
      if (grant_any) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
        done_src <= grant_ld ? SRC_LD : SRC_ALU;
      end
      // The loss streak only grows while an ALU result is actually waiting.
      if (grant_alu) begin
        state    <= ST_NORMAL;
        loss_cnt <= '0;
      end else if (!alu_hold_valid) begin
        loss_cnt <= '0;
      end else if (loss_inc >= LIMIT_W) begin
        loss_cnt <= LIMIT_W[CW-1:0];
        state    <= ST_STARVE;
      end else begin
        loss_cnt <= loss_inc[CW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter against a queue-level reference model.
module tb_writeback_arbiter;

  localparam int XLEN = 64;
  localparam int LIMIT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            alu_valid, ld_valid;
  logic            alu_ready, ld_ready;
  logic [4:0]      alu_rd, ld_rd;
  logic [XLEN-1:0] alu_data, ld_data;
  logic            rf_we, write_back_done, done_src;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_rd           (ld_rd),
    .ld_data         (ld_data),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .write_back_done (write_back_done),
    .done_src        (done_src)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: one waiting item per source, a loss streak and an ALU-priority flag.
  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } item_t;
  item_t q_alu[$];
  item_t q_ld[$];
  int    streak;
  bit    alu_prio;
  bit              e_we, e_done, e_src;
  logic [4:0]      e_addr;
  logic [XLEN-1:0] e_data;

  bit sat_mode;
  bit seen_alu;
  int ld_run;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_alu.delete();
    q_ld.delete();
    streak = 0;
    alu_prio = 0;
    e_we = 0; e_done = 0; e_src = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                       input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
                       input bit fl);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    flush = fl;
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic cycle(input string tag);
    bit ga, gl, ra, rl, acc_a, acc_l, fl;
    item_t na, nl, w;
    #1;
    fl = flush;
    gl = !fl && q_ld.size() != 0 && (q_alu.size() == 0 || !alu_prio);
    ga = !fl && q_alu.size() != 0 && !gl;
    ra = !fl && (q_alu.size() == 0 || ga);
    rl = !fl && (q_ld.size() == 0 || gl);
    chk({tag, "/alu_ready"}, alu_ready, ra);
    chk({tag, "/ld_ready"}, ld_ready, rl);
    acc_a = alu_valid && ra;
    acc_l = ld_valid && rl;
    na.rd = alu_rd; na.data = alu_data;
    nl.rd = ld_rd;  nl.data = ld_data;
    @(posedge clk);
    if (fl) begin
      q_alu.delete();
      q_ld.delete();
      streak = 0;
      alu_prio = 0;
      e_we = 0;
      e_done = 0;
    end else begin
      e_done = ga || gl;
      e_we = 0;
      if (ga || gl) begin
        w = gl ? q_ld.pop_front() : q_alu.pop_front();
        e_src = gl;
        e_addr = w.rd;
        e_data = w.data;
        e_we = (w.rd != 0);
      end
      if (ga) begin
        streak = 0;
        alu_prio = 0;
      end else if (q_alu.size() == 0) begin
        streak = 0;
      end else begin
        streak++;
        if (streak >= LIMIT) alu_prio = 1;
      end
      if (acc_a) q_alu.push_back(na);
      if (acc_l) q_ld.push_back(nl);
    end
    #1;
    chk({tag, "/rf_we"}, rf_we, e_we);
    chk({tag, "/done"}, write_back_done, e_done);
    chk({tag, "/done_src"}, done_src, e_src);
    chk({tag, "/rf_waddr"}, rf_waddr, e_addr);
    chk({tag, "/rf_wdata"}, rf_wdata, e_data);
    if (sat_mode && write_back_done) begin
      if (done_src) ld_run++;
      else begin
        if (seen_alu) chk("sat/loads_between_alu", ld_run, 3);
        seen_alu = 1;
        ld_run = 0;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/rf_we"}, rf_we, 0);
    chk({tag, "/rf_waddr"}, rf_waddr, 0);
    chk({tag, "/rf_wdata"}, rf_wdata, 0);
    chk({tag, "/done"}, write_back_done, 0);
    chk({tag, "/done_src"}, done_src, 0);
    chk({tag, "/alu_ready"}, alu_ready, 0);
    chk({tag, "/ld_ready"}, ld_ready, 0);
  endtask

  function automatic logic [XLEN-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  initial begin
    sat_mode = 0; seen_alu = 0; ld_run = 0;
    reset = 1'b0;
    idle();
    model_reset();
    #2;
    chk_all_zero("reset");
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU result.
    drive(1, 5'd5, 64'h1234, 0, '0, '0, 0);
    cycle("r33_accept");
    idle();
    cycle("r33_write");
    chk("r33/rf_we", rf_we, 1);
    chk("r33/rf_waddr", rf_waddr, 5);
    chk("r33/rf_wdata", rf_wdata, 64'h1234);
    chk("r33/done_src", done_src, 0);
    cycle("r33_after");
    chk("r33/single_pulse", write_back_done, 0);

    // Same-edge contention: load first, ALU next.
    drive(1, 5'd3, 64'hA3, 1, 5'd4, 64'hB4, 0);
    cycle("r34_accept");
    idle();
    #1;
    chk("r34/alu_ready_held", alu_ready, 0);
    cycle("r34_ld");
    chk("r34/ld_addr", rf_waddr, 4);
    cycle("r34_alu");
    chk("r34/alu_addr", rf_waddr, 3);
    cycle("r34_idle");

    // Load to x0 retires without a write.
    drive(0, '0, '0, 1, 5'd0, 64'hFF, 0);
    cycle("r36_accept");
    idle();
    cycle("r36_retire");
    chk("r36/done", write_back_done, 1);
    chk("r36/done_src", done_src, 1);
    chk("r36/rf_we", rf_we, 0);

    // Flush with both slots occupied.
    drive(1, 5'd7, 64'h77, 1, 5'd8, 64'h88, 0);
    cycle("r37_fill");
    drive(1, 5'd9, 64'h99, 1, 5'd10, 64'hAA, 1);
    cycle("r37_flush");
    chk("r37/no_we", rf_we, 0);
    idle();
    #1;
    chk("r37/alu_ready_back", alu_ready, 1);
    chk("r37/ld_ready_back", ld_ready, 1);
    cycle("r37_post");
    cycle("r37_post2");

    // Both sources saturated.
    sat_mode = 1;
    for (int i = 0; i < 48; i++) begin
      drive(1, 5'($urandom_range(1, 31)), rnd_data(), 1, 5'($urandom_range(1, 31)), rnd_data(), 0);
      cycle("sat");
    end
    sat_mode = 0;
    idle();
    repeat (3) cycle("sat_drain");

    // Random traffic with occasional flushes and x0 destinations.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), rnd_data(),
            $urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), rnd_data(),
            $urandom_range(0, 19) == 0);
      cycle("rand");
    end

    // Reset mid-stream with both slots occupied.
    drive(1, 5'd11, 64'h1111, 1, 5'd12, 64'h2222, 0);
    cycle("r38_fill");
    drive(1, 5'd13, 64'h3333, 1, 5'd14, 64'h4444, 0);
    cycle("r38_busy");
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("r38_in_reset");
    model_reset();
    idle();
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) cycle("r38_after");
    drive(1, 5'd15, 64'h5555, 0, '0, '0, 0);
    cycle("r38_new");
    idle();
    cycle("r38_new_write");
    cycle("r38_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
